// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Holds the controller FSM encoding, the register-index width, the
// zero-register constant and a small source/destination match helper.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_TMO  = 2'd2
    } hz_state_e;

    // True when the ID instruction really reads 'src' and it names 'dst'.
    function automatic logic src_match(input logic     use_src,
                                       input reg_idx_t src,
                                       input reg_idx_t dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline and the controller.
// master : pipeline side, drives the ID/EX/MEM observations and err_clr,
//          receives the pause/nop controls, the sticky error and the counters.
// slave  : hazard controller side (the reverse directions).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    import pipe_hazard_ctrl_pkg::*;

    reg_idx_t           id_rs1;
    reg_idx_t           id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    reg_idx_t           ex_rd;
    logic               ex_memrd;
    logic               ex_regwr;
    logic               ex_redirect;
    logic               mem_busy;
    logic               err_clr;

    logic               pc_pause;
    logic               ifid_pause;
    logic               idex_pause;
    logic               exmem_pause;
    logic               ifid_nop;
    logic               idex_nop;
    logic               memwb_nop;
    logic               timeout_err;
    logic [CNT_W-1:0]   lu_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]   wait_cnt_total;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, ex_memrd, ex_regwr, ex_redirect, mem_busy, err_clr,
        input  pc_pause, ifid_pause, idex_pause, exmem_pause,
               ifid_nop, idex_nop, memwb_nop,
               timeout_err, lu_cnt, flush_cnt, wait_cnt_total
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, ex_memrd, ex_regwr, ex_redirect, mem_busy, err_clr,
        output pc_pause, ifid_pause, idex_pause, exmem_pause,
               ifid_nop, idex_nop, memwb_nop,
               timeout_err, lu_cnt, flush_cnt, wait_cnt_total
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports: clk, rst (async, active-low), inc (count this cycle),
//        count (current value; sticks at all-ones, never wraps).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    // Count register: increments on inc until it reaches all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= {W{1'b0}};
        end else if (inc && (count != ALL_ONES)) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Decodes load-use, EX redirect and data-memory wait into nop/pause
// controls for the PC and the pipeline registers (combinational), tracks
// memory-wait duration to raise a sticky timeout flag, and keeps three
// saturating event counters.
// Ports: clk, rst (async, active-low), hz (slave side of the hazard bundle).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    // wcnt only ever needs to hold values up to MEM_TIMEOUT-1.
    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_ZERO = WCNT_W'(0);

    hz_state_e          state_r;
    hz_state_e          state_nxt_s;
    logic [WCNT_W-1:0]  wcnt_r;
    logic [WCNT_W-1:0]  wcnt_nxt_s;
    logic               err_r;
    logic               err_nxt_s;
    logic               err_set_s;

    logic               lu_hit_s;
    logic               act_freeze_s;
    logic               act_redirect_s;
    logic               act_lu_s;

    logic               pc_pause_s;
    logic               ifid_pause_s;
    logic               idex_pause_s;
    logic               exmem_pause_s;
    logic               ifid_nop_s;
    logic               idex_nop_s;
    logic               memwb_nop_s;

    logic [CNT_W-1:0]   lu_cnt_s;
    logic [CNT_W-1:0]   flush_cnt_s;
    logic [CNT_W-1:0]   wait_cnt_s;

    assign lu_hit_s = hz.ex_memrd && hz.ex_regwr && (hz.ex_rd != ZERO_REG) &&
                      (src_match(hz.id_use_rs1, hz.id_rs1, hz.ex_rd) ||
                       src_match(hz.id_use_rs2, hz.id_rs2, hz.ex_rd));

    // One action per cycle: memory freeze beats redirect beats load-use.
    // Deferred hazards stay visible because EX is held during a freeze.
    assign act_freeze_s   = hz.mem_busy;
    assign act_redirect_s = !hz.mem_busy && hz.ex_redirect;
    assign act_lu_s       = !hz.mem_busy && !hz.ex_redirect && lu_hit_s;

    // State register: FSM state, wait-length counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
            wcnt_r  <= WCNT_ZERO;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next-state logic: measure consecutive busy cycles, flag the timeout.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        err_set_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (hz.mem_busy) begin
                    state_nxt_s = ST_WAIT;
                    wcnt_nxt_s  = WCNT_ONE;
                end else begin
                    state_nxt_s = ST_RUN;
                    wcnt_nxt_s  = WCNT_ZERO;
                end
            end
            ST_WAIT: begin
                if (!hz.mem_busy) begin
                    state_nxt_s = ST_RUN;
                    wcnt_nxt_s  = WCNT_ZERO;
                end else if (wcnt_r == WCNT_LAST) begin
                    state_nxt_s = ST_TMO;
                    err_set_s   = 1'b1;
                end else begin
                    wcnt_nxt_s  = wcnt_r + WCNT_ONE;
                end
            end
            ST_TMO: begin
                if (!hz.mem_busy) begin
                    state_nxt_s = ST_RUN;
                    wcnt_nxt_s  = WCNT_ZERO;
                end else begin
                    state_nxt_s = ST_TMO;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                wcnt_nxt_s  = WCNT_ZERO;
            end
        endcase

        // A new timeout on the same edge as err_clr must not be lost.
        if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (hz.err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Output decode: pause/nop controls, forced low while reset is asserted.
    always_comb begin
        pc_pause_s    = 1'b0;
        ifid_pause_s  = 1'b0;
        idex_pause_s  = 1'b0;
        exmem_pause_s = 1'b0;
        ifid_nop_s    = 1'b0;
        idex_nop_s    = 1'b0;
        memwb_nop_s   = 1'b0;
        if (!rst) begin
            pc_pause_s = 1'b0;
        end else if (act_freeze_s) begin
            // Hold everything up to EX/MEM and drain a bubble into MEM/WB.
            pc_pause_s    = 1'b1;
            ifid_pause_s  = 1'b1;
            idex_pause_s  = 1'b1;
            exmem_pause_s = 1'b1;
            memwb_nop_s   = 1'b1;
        end else if (act_redirect_s) begin
            // PC takes the target, so it is not paused.
            ifid_nop_s = 1'b1;
            idex_nop_s = 1'b1;
        end else if (act_lu_s) begin
            pc_pause_s   = 1'b1;
            ifid_pause_s = 1'b1;
            idex_nop_s   = 1'b1;
        end else begin
            pc_pause_s = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act_lu_s),
        .count (lu_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act_redirect_s),
        .count (flush_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act_freeze_s),
        .count (wait_cnt_s)
    );

    assign hz.pc_pause       = pc_pause_s;
    assign hz.ifid_pause     = ifid_pause_s;
    assign hz.idex_pause     = idex_pause_s;
    assign hz.exmem_pause    = exmem_pause_s;
    assign hz.ifid_nop       = ifid_nop_s;
    assign hz.idex_nop       = idex_nop_s;
    assign hz.memwb_nop      = memwb_nop_s;
    assign hz.timeout_err    = err_r;
    assign hz.lu_cnt         = lu_cnt_s;
    assign hz.flush_cnt      = flush_cnt_s;
    assign hz.wait_cnt_total = wait_cnt_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Stimulus drives one vector per cycle just after the rising edge and pushes
// the hand-computed expectation; the monitor pops and compares on the
// falling edge of the same cycle.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    // ctl bits: {pc_pause, ifid_pause, idex_pause, exmem_pause, ifid_nop, idex_nop, memwb_nop}
    localparam logic [6:0] C_NONE = 7'b000_0000;
    localparam logic [6:0] C_LU   = 7'b110_0010;
    localparam logic [6:0] C_RD   = 7'b000_0110;
    localparam logic [6:0] C_FZ   = 7'b111_1001;

    typedef struct {
        string          nm;
        logic [6:0]     ctl;
        logic [CW-1:0]  lu;
        logic [CW-1:0]  fl;
        logic [CW-1:0]  wt;
        logic           err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic memrd, input logic regwr, input logic redir,
                         input logic busy, input logic clr);
        hz.id_rs1      = rs1;
        hz.id_rs2      = rs2;
        hz.id_use_rs1  = u1;
        hz.id_use_rs2  = u2;
        hz.ex_rd       = rd;
        hz.ex_memrd    = memrd;
        hz.ex_regwr    = regwr;
        hz.ex_redirect = redir;
        hz.mem_busy    = busy;
        hz.err_clr     = clr;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string nm, input logic [6:0] ctl, input int lu,
                              input int fl, input int wt, input logic err);
        exp_t e;
        e.nm  = nm;
        e.ctl = ctl;
        e.lu  = CW'(lu);
        e.fl  = CW'(fl);
        e.wt  = CW'(wt);
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every pending expectation mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [6:0] act_ctl;
            e = sb_q.pop_front();
            act_ctl = {hz.pc_pause, hz.ifid_pause, hz.idex_pause, hz.exmem_pause,
                       hz.ifid_nop, hz.idex_nop, hz.memwb_nop};
            checks++;
            if (act_ctl !== e.ctl || hz.lu_cnt !== e.lu || hz.flush_cnt !== e.fl ||
                hz.wait_cnt_total !== e.wt || hz.timeout_err !== e.err) begin
                failures++;
                $display("FAIL %s: got ctl=%b lu=%0d fl=%0d wt=%0d err=%b, required ctl=%b lu=%0d fl=%0d wt=%0d err=%b",
                         e.nm, act_ctl, hz.lu_cnt, hz.flush_cnt, hz.wait_cnt_total,
                         hz.timeout_err, e.ctl, e.lu, e.fl, e.wt, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        // Hazards presented during reset must not reach the outputs.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(); expect_out("reset_hold", C_NONE, 0, 0, 0, 1'b0);
        tick(); rst = 1'b1; idle(); expect_out("idle", C_NONE, 0, 0, 0, 1'b0);

        // Load-use on rs2, then the non-hazard variants.
        tick(); drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("lu_rs2", C_LU, 0, 0, 0, 1'b0);
        tick(); idle(); expect_out("lu_cnt_inc", C_NONE, 1, 0, 0, 1'b0);
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("lu_rd_x0", C_NONE, 1, 0, 0, 1'b0);
        tick(); drive(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("lu_rs2_unused", C_NONE, 1, 0, 0, 1'b0);
        tick(); drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("lu_rs1", C_LU, 1, 0, 0, 1'b0);
        tick(); drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("not_load", C_NONE, 2, 0, 0, 1'b0);

        // Redirect beats a coincident load-use.
        tick(); drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("redir_lu", C_RD, 2, 0, 0, 1'b0);
        tick(); idle(); expect_out("redir_cnt", C_NONE, 2, 1, 0, 1'b0);

        // Reset clears counters immediately.
        tick(); rst = 1'b0; expect_out("reset_clr", C_NONE, 0, 0, 0, 1'b0);
        tick(); rst = 1'b1; expect_out("reset_rel", C_NONE, 0, 0, 0, 1'b0);

        // Three busy cycles with redirect and load-use pending: freeze only.
        for (int c = 0; c < 3; c++) begin
            tick(); drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            expect_out("freeze_redir", C_FZ, 0, 0, c, 1'b0);
        end
        tick(); drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("redir_after_freeze", C_RD, 0, 0, 3, 1'b0);
        tick(); idle(); expect_out("flush_once", C_NONE, 0, 1, 3, 1'b0);

        // Six busy cycles: timeout flag visible from the fifth.
        for (int c = 0; c < 6; c++) begin
            tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            expect_out("tmo_busy", C_FZ, 0, 1, 3 + c, (c >= 4) ? 1'b1 : 1'b0);
        end
        tick(); idle(); expect_out("tmo_sticky", C_NONE, 0, 1, 9, 1'b1);
        tick(); idle(); expect_out("tmo_sticky2", C_NONE, 0, 1, 9, 1'b1);
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("clr_pulse", C_NONE, 0, 1, 9, 1'b1);
        tick(); idle(); expect_out("clr_done", C_NONE, 0, 1, 9, 1'b0);

        // err_clr held through a new timeout edge: set wins.
        for (int c = 0; c < 4; c++) begin
            tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            expect_out("set_vs_clr", C_FZ, 0, 1, 9 + c, 1'b0);
        end
        tick(); idle(); expect_out("set_wins", C_NONE, 0, 1, 13, 1'b1);

        // Asynchronous reset in the middle of a wait.
        tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("wait_a", C_FZ, 0, 1, 13, 1'b1);
        tick(); expect_out("wait_b", C_FZ, 0, 1, 14, 1'b1);
        tick(); rst = 1'b0; expect_out("reset_midwait", C_NONE, 0, 0, 0, 1'b0);
        tick(); rst = 1'b1; idle(); expect_out("reset_midwait_rel", C_NONE, 0, 0, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick(); drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            expect_out("post_reset_wait", C_FZ, 0, 0, c, 1'b0);
        end
        tick(); idle(); expect_out("post_reset_run", C_NONE, 0, 0, 3, 1'b0);

        // Twenty load-use cycles: counter saturates at 15.
        for (int k = 0; k < 20; k++) begin
            tick(); drive(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            expect_out("lu_sat", C_LU, (k > 15) ? 15 : k, 0, 3, 1'b0);
        end
        tick(); idle(); expect_out("lu_sat_hold", C_NONE, 15, 0, 3, 1'b0);

        tick();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
